// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Single-port data memory access unit. Accepts one request at
//                a time, resolves stack or direct addressing, checks address
//                and stack bounds, performs narrow (one word) or wide (two
//                word) reads and writes, and tracks the stack pointer and
//                exception PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] SP_INIT   = {ADDR_W{1'b1}},
  parameter logic [ADDR_W-1:0] EXC_LIMIT = 12'hF00
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic                  i_en32,
  input  logic                  i_isStack,
  input  logic                  i_isPush,
  input  logic                  i_isPushPc,
  input  logic [ADDR_W-1:0]     i_aluAddr,
  input  logic [2*WORD_W-1:0]   i_wdata,
  input  logic [2*WORD_W-1:0]   i_pc,
  input  logic [3:0]            i_flags,
  input  logic [1:0]            i_wb,
  input  logic                  i_clrEpc,
  output logic                  o_valid,
  output logic [2*WORD_W-1:0]   o_rdata,
  output logic [1:0]            o_wb,
  output logic [1:0]            o_exc,
  output logic [ADDR_W-1:0]     o_sp,
  output logic [2*WORD_W-1:0]   o_epc
);

  localparam int                DW    = 2 * WORD_W;
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   ONE_X = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   TWO_X = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0]   TOP_X = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [1:0]        EXC_NONE  = 2'b00;
  localparam logic [1:0]        EXC_ADDR  = 2'b01;
  localparam logic [1:0]        EXC_STACK = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic              rd_q, wr_q, wide_q;
  logic [1:0]        exc_q, wb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     wdata_q;

  // Architectural state
  logic [ADDR_W-1:0] sp_q;
  logic [DW-1:0]     epc_q;
  logic [DW-1:0]     rdata_q;

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Request decode
  logic              accept;
  logic              access;
  logic [ADDR_W:0]   n_x;
  logic [ADDR_W-1:0] n_a;
  logic [ADDR_W:0]   sp_x;
  logic [ADDR_W:0]   alu_x;
  logic [1:0]        exc_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] sp_d;
  logic [DW-1:0]     wdata_d;

  // Memory port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rd;

  assign o_ready = (state_q == IDLE);
  assign accept  = i_valid && (state_q == IDLE);
  // A request with neither read nor write is a no-op: no bounds check and
  // the stack pointer is left alone.
  assign access  = i_memRead | i_memWrite;

  // Effective address, next SP, exception class and write data for the
  // request presented at the input.
  always_comb begin
    n_x     = i_en32 ? TWO_X : ONE_X;
    n_a     = n_x[ADDR_W-1:0];
    sp_x    = {1'b0, sp_q};
    alu_x   = {1'b0, i_aluAddr};
    exc_d   = EXC_NONE;
    addr_d  = i_aluAddr;
    sp_d    = sp_q;
    wdata_d = i_isPushPc ? ((i_pc + DW'(1)) | {i_flags, {(DW-4){1'b0}}}) : i_wdata;
    if (access) begin
      if (i_isStack) begin
        if (i_isPush) begin
          // Push needs n free words at or below SP: SP >= n-1.
          if (sp_x + ONE_X < n_x) begin
            exc_d = EXC_STACK;
          end else begin
            addr_d = sp_q - n_a + ONE_A;
            sp_d   = sp_q - n_a;
          end
        end else begin
          // Pop reads above SP and must not run past the top of memory.
          if (sp_x + n_x > TOP_X) begin
            exc_d = EXC_STACK;
          end else begin
            addr_d = sp_q + ONE_A;
            sp_d   = sp_q + n_a;
          end
        end
      end else if (alu_x + n_x - ONE_X >= {1'b0, EXC_LIMIT}) begin
        exc_d = EXC_ADDR;
      end
    end
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_valid) state_d = (access && (exc_d == EXC_NONE)) ? LO : RESP;
      LO:   state_d = wide_q ? HI : RESP;
      HI:   state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Memory port: low word in LO at the base address, high word in HI at the
  // following address. Reset suppresses any write still in flight.
  assign mem_addr  = (state_q == HI) ? (addr_q + ONE_A) : addr_q;
  assign mem_wdata = (state_q == HI) ? wdata_q[DW-1:WORD_W] : wdata_q[WORD_W-1:0];
  assign mem_we    = ((state_q == LO) || (state_q == HI)) && wr_q && !i_reset;
  assign mem_rd    = mem_q[mem_addr];

  // Synchronous memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Request latch, stack pointer, exception PC and read-data assembly.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wide_q  <= 1'b0;
      exc_q   <= EXC_NONE;
      wb_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      sp_q    <= SP_INIT;
      epc_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        rd_q    <= i_memRead;
        wr_q    <= i_memWrite;
        wide_q  <= i_en32;
        exc_q   <= exc_d;
        wb_q    <= i_wb;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        sp_q    <= sp_d;
        rdata_q <= '0;
      end
      // Exception capture takes priority over a simultaneous clear.
      if (accept && (exc_d != EXC_NONE)) epc_q <= i_pc;
      else if (i_clrEpc)                 epc_q <= '0;
      // A combined read+write returns zero, so only pure reads load data.
      if ((state_q == LO) && rd_q && !wr_q) rdata_q[WORD_W-1:0]  <= mem_rd;
      if ((state_q == HI) && rd_q && !wr_q) rdata_q[DW-1:WORD_W] <= mem_rd;
    end
  end

  assign o_valid = (state_q == RESP);
  assign o_exc   = (state_q == RESP) ? exc_q : EXC_NONE;
  assign o_wb    = ((state_q == RESP) && (exc_q == EXC_NONE)) ? wb_q : 2'b00;
  assign o_rdata = rdata_q;
  assign o_sp    = sp_q;
  assign o_epc   = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit: directed scenarios
//                plus randomized requests against a word-array reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_memRead, i_memWrite, i_en32;
  logic        i_isStack, i_isPush, i_isPushPc, i_clrEpc;
  logic [11:0] i_aluAddr;
  logic [31:0] i_wdata, i_pc;
  logic [3:0]  i_flags;
  logic [1:0]  i_wb;
  logic        o_ready, o_valid;
  logic [31:0] o_rdata, o_epc;
  logic [1:0]  o_wb, o_exc;
  logic [11:0] o_sp;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit [15:0]   mem_m [DEPTH];
  int          sp_m;
  logic [31:0] epc_m;

  mem_access_unit dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_en32(i_en32),
    .i_isStack(i_isStack), .i_isPush(i_isPush), .i_isPushPc(i_isPushPc),
    .i_aluAddr(i_aluAddr), .i_wdata(i_wdata), .i_pc(i_pc), .i_flags(i_flags),
    .i_wb(i_wb), .i_clrEpc(i_clrEpc), .o_valid(o_valid), .o_rdata(o_rdata),
    .o_wb(o_wb), .o_exc(o_exc), .o_sp(o_sp), .o_epc(o_epc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request: model update, drive, latency and response checks.
  task automatic do_req(input bit rd, input bit wr, input bit en32, input bit stk,
                        input bit push, input bit ppc, input bit [11:0] alu,
                        input bit [31:0] wd, input bit [31:0] pc, input bit [3:0] fl,
                        input bit [1:0] wb, input bit clr, output logic [31:0] got);
    int n, addr, sp_nx, lat, exp_lat, w;
    bit acc;
    bit [1:0]  exp_exc;
    bit [31:0] data, exp_rd;
    n = en32 ? 2 : 1;
    acc = rd | wr;
    addr = alu;
    sp_nx = sp_m;
    exp_exc = 2'b00;
    if (acc && stk && push) begin
      if (sp_m < n - 1) exp_exc = 2'b10;
      else begin
        addr  = ((sp_m - n + 1) % DEPTH + DEPTH) % DEPTH;
        sp_nx = ((sp_m - n) % DEPTH + DEPTH) % DEPTH;
      end
    end else if (acc && stk) begin
      if (sp_m + n > DEPTH - 1) exp_exc = 2'b10;
      else begin
        addr  = (sp_m + 1) % DEPTH;
        sp_nx = sp_m + n;
      end
    end else if (acc) begin
      if (int'(alu) + n - 1 >= 'hF00) exp_exc = 2'b01;
    end
    data = ppc ? ((pc + 32'd1) | {fl, 28'h0}) : wd;
    exp_rd = 32'h0;
    if (exp_exc == 2'b00 && rd && !wr)
      exp_rd = {(n == 2) ? mem_m[(addr + 1) % DEPTH] : 16'h0, mem_m[addr]};
    if (exp_exc == 2'b00 && wr) begin
      mem_m[addr] = data[15:0];
      if (n == 2) mem_m[(addr + 1) % DEPTH] = data[31:16];
    end
    if (exp_exc == 2'b00) sp_m = sp_nx;
    if (exp_exc != 2'b00) epc_m = pc;
    else if (clr)         epc_m = 32'h0;
    exp_lat = (exp_exc != 2'b00 || !acc) ? 1 : n + 1;

    @(negedge clk);
    w = 0;
    while (o_ready !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    check("ready", o_ready, 1'b1);
    i_memRead = rd; i_memWrite = wr; i_en32 = en32; i_isStack = stk;
    i_isPush = push; i_isPushPc = ppc; i_aluAddr = alu; i_wdata = wd;
    i_pc = pc; i_flags = fl; i_wb = wb; i_clrEpc = clr; i_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      i_valid = 1'b0; i_clrEpc = 1'b0;
      lat++;
    end while (o_valid !== 1'b1 && lat < 6);
    check("latency", lat, exp_lat);
    check("exc", o_exc, exp_exc);
    check("wb", o_wb, (exp_exc == 2'b00) ? wb : 2'b00);
    check("rdata", o_rdata, exp_rd);
    check("sp", o_sp, sp_m);
    check("epc", o_epc, epc_m);
    got = o_rdata;
    @(posedge clk); #1;
    check("hold_valid", o_valid, 1'b0);
    check("hold_rdata", o_rdata, exp_rd);
    check("hold_exc", o_exc, 2'b00);
  endtask

  initial begin
    logic [31:0] got;
    bit rd, wr, en32, stk, push, ppc, clr;
    bit [11:0] alu;
    bit [31:0] wd, pc;
    bit [3:0]  fl;
    bit [1:0]  wb;

    // Reset with a request held on i_valid: reset must win.
    i_reset = 1'b1; i_valid = 1'b1; i_memRead = 1'b0; i_memWrite = 1'b1;
    i_en32 = 1'b0; i_isStack = 1'b0; i_isPush = 1'b0; i_isPushPc = 1'b0;
    i_aluAddr = 12'h005; i_wdata = 32'h0; i_pc = 32'h0; i_flags = 4'h0;
    i_wb = 2'b00; i_clrEpc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0; i_valid = 1'b0; i_memWrite = 1'b0;
    sp_m = 'hFFF; epc_m = 32'h0;
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_wb", o_wb, 2'b00);
    check("rst_exc", o_exc, 2'b00);
    check("rst_sp", o_sp, 12'hFFF);
    check("rst_epc", o_epc, 32'h0);

    // Wide push then wide pop from reset SP.
    do_req(0, 1, 1, 1, 1, 0, 12'h0, 32'hDEADBEEF, 32'h10, 4'h0, 2'b01, 0, got);
    check("push_sp", o_sp, 12'hFFD);
    do_req(1, 0, 1, 1, 0, 0, 12'h0, 32'h0, 32'h11, 4'h0, 2'b10, 0, got);
    check("pop_data", got, 32'hDEADBEEF);
    check("pop_sp", o_sp, 12'hFFF);

    // Narrow pop at top of stack raises a stack exception.
    do_req(1, 0, 0, 1, 0, 0, 12'h0, 32'h0, 32'h00000ABC, 4'h0, 2'b11, 0, got);
    check("popexc_epc", o_epc, 32'h00000ABC);
    check("popexc_sp", o_sp, 12'hFFF);

    // Narrow write then read back.
    do_req(0, 1, 0, 0, 0, 0, 12'h010, 32'h00001234, 32'h20, 4'h0, 2'b01, 0, got);
    do_req(1, 0, 0, 0, 0, 0, 12'h010, 32'h0, 32'h21, 4'h0, 2'b01, 0, got);
    check("narrow_read", got, 32'h00001234);

    // Wide write straddling the limit: address exception, memory untouched.
    do_req(0, 1, 0, 0, 0, 0, 12'hEFF, 32'h00007777, 32'h30, 4'h0, 2'b01, 0, got);
    do_req(0, 1, 1, 0, 0, 0, 12'hEFF, 32'h11112222, 32'h00000055, 4'h0, 2'b01, 0, got);
    check("addrexc_epc", o_epc, 32'h00000055);
    do_req(0, 0, 0, 0, 0, 0, 12'h0, 32'h0, 32'h31, 4'h0, 2'b00, 1, got);
    check("clr_epc", o_epc, 32'h0);
    do_req(1, 0, 0, 0, 0, 0, 12'hEFF, 32'h0, 32'h32, 4'h0, 2'b01, 0, got);
    check("limit_unchanged", got, 32'h00007777);

    // Wide push of PC+1 with flags in the top nibble.
    do_req(0, 1, 1, 1, 1, 1, 12'h0, 32'h0, 32'h00000100, 4'b1010, 2'b00, 0, got);
    do_req(1, 0, 1, 1, 0, 0, 12'h0, 32'h0, 32'h40, 4'h0, 2'b00, 0, got);
    check("pushpc_word", got, 32'hA0000101);

    // Preload regions touched by random traffic.
    for (int a = 0; a <= 'h20; a += 2)
      do_req(0, 1, 1, 0, 0, 0, 12'(a), $urandom, 32'h0, 4'h0, 2'b00, 0, got);
    for (int a = 'hEF0; a <= 'hEFE; a += 2)
      do_req(0, 1, 1, 0, 0, 0, 12'(a), $urandom, 32'h0, 4'h0, 2'b00, 0, got);
    for (int k = 0; k < 32; k++)
      do_req(0, 1, 1, 1, 1, 0, 12'h0, $urandom, 32'h0, 4'h0, 2'b00, 0, got);

    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      {rd, wr} = 2'($urandom_range(0, 3));
      en32 = 1'($urandom_range(0, 1));
      stk  = ($urandom_range(0, 9) < 6);
      push = (sp_m >= 'hFC1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 3) == 0) alu = 12'hEF0 + 12'($urandom_range(0, 31));
      else                           alu = 12'($urandom_range(0, 31));
      ppc = ($urandom_range(0, 7) == 0);
      wd  = $urandom;
      pc  = $urandom;
      fl  = 4'($urandom_range(0, 15));
      wb  = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 5) == 0);
      do_req(rd, wr, en32, stk, push, ppc, alu, wd, pc, fl, wb, clr, got);
    end

    // Reset in the HI cycle of a wide write aborts the high-word write.
    @(negedge clk);
    check("abort_ready", o_ready, 1'b1);
    i_memRead = 1'b0; i_memWrite = 1'b1; i_en32 = 1'b1; i_isStack = 1'b0;
    i_isPush = 1'b0; i_isPushPc = 1'b0; i_aluAddr = 12'h020;
    i_wdata = 32'h5A5AC3C3; i_wb = 2'b01; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", o_ready, 1'b0);
    @(negedge clk); i_reset = 1'b1;
    @(posedge clk); #1; i_reset = 1'b0;
    mem_m['h020] = 16'hC3C3;
    sp_m = 'hFFF; epc_m = 32'h0;
    check("abort_valid", o_valid, 1'b0);
    check("abort_ready_after", o_ready, 1'b1);
    check("abort_sp", o_sp, 12'hFFF);
    check("abort_epc", o_epc, 32'h0);
    @(posedge clk); #1;
    check("abort_no_resp", o_valid, 1'b0);
    do_req(1, 0, 1, 0, 0, 0, 12'h020, 32'h0, 32'h50, 4'h0, 2'b01, 0, got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WORD_W, default 16, memory word width; wide accesses are 2*WORD_W.
REQ-002 Parameter ADDR_W, default 12, word-address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter SP_INIT, default DEPTH-1, stack pointer value after reset.
REQ-004 Parameter EXC_LIMIT, default 12'hF00, first illegal non-stack word address.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_valid / o_ready  in / out  1 / 1  request handshake; transfer when both high.
REQ-008 i_memRead, i_memWrite, i_en32  in  1 each  read, write, wide (two-word) access.
REQ-009 i_isStack, i_isPush, i_isPushPc  in  1 each  SP addressing, push (else pop), write PC+flags.
REQ-010 i_aluAddr  in  ADDR_W  non-stack address; i_wdata  in  2*WORD_W  write data.
REQ-011 i_pc  in  2*WORD_W  instruction PC; i_flags  in  4  CCR flags; i_wb  in  2  writeback ctrl.
REQ-012 i_clrEpc  in  1  clears EPC.
REQ-013 o_valid  out  1  one-cycle response strobe; o_rdata  out  2*WORD_W  read data.
REQ-014 o_wb  out  2; o_exc  out  2 (00 none, 01 address, 10 stack); o_sp, o_epc  out  ADDR_W / 2*WORD_W.

Function
REQ-015 Internal memory: DEPTH x WORD_W, synchronous write, not reset; wide access: low half at addr, high half at addr+1 (mod DEPTH).
REQ-016 FSM states IDLE, LO, HI, RESP; o_ready=1 only in IDLE; request and all inputs latched on accept.
REQ-017 Transitions: IDLE->LO on accept (no exception, read or write); IDLE->RESP on accept with exception or neither read nor write; LO->HI if wide else LO->RESP; HI->RESP; RESP->IDLE.
REQ-018 Latency accept-to-o_valid: narrow 2 cycles, wide 3 cycles, exception/no-op 1 cycle; o_valid high exactly in RESP.
REQ-019 n = 2 if i_en32 else 1; push address = SP-n+1, SP_next = SP-n; pop address = SP+1, SP_next = SP+n; non-stack address = i_aluAddr; all mod DEPTH.
REQ-020 SP updates on the accept edge only; o_sp shows the current register.
REQ-021 Stack exception (10): push with SP < n-1, or pop with SP+n > DEPTH-1; SP unchanged.
REQ-022 Address exception (01): non-stack access with i_aluAddr+n-1 >= EXC_LIMIT (no wrap).
REQ-023 On exception: no memory write, o_wb=00, o_rdata=0, o_exc valid with o_valid, EPC <= i_pc at accept edge.
REQ-024 i_clrEpc clears EPC to 0 on next edge; exception capture on the same edge wins.
REQ-025 Write data = i_isPushPc ? ((i_pc+1) | {i_flags, zeros}) : i_wdata, flags in top 4 bits.
REQ-026 Read and write both set: write performed, o_rdata=0.
REQ-027 Read: o_rdata loaded from words in LO/HI (high half 0 if narrow), held stable from RESP until next accept.
REQ-028 o_wb = latched i_wb in RESP without exception, else 00; o_exc=00 outside RESP.

Reset
REQ-029 On i_reset edge: state IDLE, SP=SP_INIT, EPC=0, o_valid=0, o_rdata=0, o_wb=00, o_exc=00; memory contents retained.
REQ-030 Reset mid-access (LO or HI) aborts: pending high-half write not performed, no o_valid.
REQ-031 i_reset overrides i_valid on the same edge; o_ready=1 the cycle after reset.

Verification
REQ-032 Narrow write 0x1234 to 0x010, then narrow read 0x010 -> o_valid 2 cycles after accept, o_rdata=0x00001234.
REQ-033 Wide push 0xDEADBEEF from reset (SP=0xFFF) -> words 0xFFE=0xBEEF, 0xFFF=0xDEAD, SP=0xFFD; wide pop -> o_rdata=0xDEADBEEF, SP=0xFFF.
REQ-034 Narrow pop at SP=0xFFF -> o_exc=10, o_wb=00, SP stays 0xFFF, o_epc=i_pc, 1-cycle latency.
REQ-035 Wide write at 0xEFF -> o_exc=01, words 0xEFF/0xF00 unchanged; EPC captured; i_clrEpc -> o_epc=0.
REQ-036 PushPc wide, i_pc=0x00000100, i_flags=4'b1010 -> stored 0xA0000101.
REQ-037 i_reset asserted in HI of wide write -> high word unwritten, SP=0xFFF, no o_valid, o_ready high next cycle.
